// File: rtl/vga_rx_if.sv
// Video-in / pixel-out bundle for vga_rx.
// slave = the receiver; master = the source driving the pins and the consumer of the pixel stream.
interface vga_rx_if;
    localparam int unsigned PIX_W = 16;
    localparam int unsigned POS_W = 11;

    logic             vga_hs;
    logic             vga_vs;
    logic [PIX_W-1:0] vga_rgb;
    logic [PIX_W-1:0] pixel_data;
    logic             pixel_valid;
    logic [POS_W-1:0] pixel_xpos;
    logic [POS_W-1:0] pixel_ypos;
    logic             frame_start;
    logic             locked;
    logic [POS_W-1:0] h_total;
    logic [POS_W-1:0] v_total;

    modport master (
        output vga_hs, vga_vs, vga_rgb,
        input  pixel_data, pixel_valid, pixel_xpos, pixel_ypos,
        input  frame_start, locked, h_total, v_total
    );

    modport slave (
        input  vga_hs, vga_vs, vga_rgb,
        output pixel_data, pixel_valid, pixel_xpos, pixel_ypos,
        output frame_start, locked, h_total, v_total
    );
endinterface

// File: rtl/vga_rx.sv
// VGA receiver: locks to incoming hs/vs timing, rebuilds pixel coordinates and emits active-window pixels.
// Optional VGA_RX_LOCK_EN: when defined, pixels are only emitted while locked.
module vga_rx #(
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BACK = 48,
    parameter int unsigned H_DISP = 640,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BACK = 33,
    parameter int unsigned V_DISP = 480
) (
    input  logic    vga_clk,
    input  logic    sys_rst,
    vga_rx_if.slave bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned LW = CW + 1;
    localparam int unsigned PW = 16;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] H_ACT_LO = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] H_ACT_HI = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_ACT_LO = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] V_ACT_HI = CW'(V_SYNC + V_BACK + V_DISP);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_e;

    state_e        state_q, state_d;
    logic          s_hs_q, s_vs_q, s_hs_dly_q, s_vs_dly_q;
    logic [PW-1:0] s_rgb_q;
    logic          hs_fall, vs_fall;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [LW-1:0] line_len_q, line_len_d, frame_len_q, frame_len_d;
    logic          saturated, h_match, v_match;
    logic [CW-1:0] h_total_q, h_total_d, v_total_q, v_total_d;
    logic          locked_q;
    logic          pix_en, in_win;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          frame_start_q, frame_start_d;

    // Input sample stage plus one delay for edge detection; idle-high reset avoids a false fall.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            s_hs_q     <= 1'b1;
            s_vs_q     <= 1'b1;
            s_hs_dly_q <= 1'b1;
            s_vs_dly_q <= 1'b1;
            s_rgb_q    <= '0;
        end else begin
            s_hs_q     <= bus.vga_hs;
            s_vs_q     <= bus.vga_vs;
            s_hs_dly_q <= s_hs_q;
            s_vs_dly_q <= s_vs_q;
            s_rgb_q    <= bus.vga_rgb;
        end
    end

    assign hs_fall = ~s_hs_q & s_hs_dly_q;
    assign vs_fall = ~s_vs_q & s_vs_dly_q;

    // h_cnt_d / v_cnt_d are the position of the pixel currently in s_rgb_q.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        line_len_d  = line_len_q;
        frame_len_d = frame_len_q;
        if (hs_fall) begin
            h_cnt_d    = '0;
            line_len_d = {1'b0, h_cnt_q} + LW'(1);
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + CW'(1);
        end
        if (vs_fall) begin
            v_cnt_d     = '0;
            frame_len_d = {1'b0, v_cnt_q} + LW'(1);
        end else if (hs_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + CW'(1);
        end
    end

    assign saturated = (h_cnt_d == CNT_MAX) || (v_cnt_d == CNT_MAX);
    assign h_match   = (line_len_d  == {1'b0, h_total_q});
    assign v_match   = (frame_len_d == {1'b0, v_total_q});

    // Lock FSM: measure one frame, confirm on the next, then police every line and frame.
    always_comb begin
        state_d   = state_q;
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        case (state_q)
            SEARCH: begin
                if (vs_fall) state_d = MEASURE;
            end
            MEASURE: begin
                if (vs_fall) begin
                    h_total_d = CW'(line_len_d);
                    v_total_d = CW'(frame_len_d);
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (vs_fall) begin
                    if (h_match && v_match) begin
                        state_d = LOCKED;
                    end else begin
                        h_total_d = CW'(line_len_d);
                        v_total_d = CW'(frame_len_d);
                    end
                end
            end
            LOCKED: begin
                if ((hs_fall && !h_match) || (vs_fall && !v_match) || saturated) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

`ifdef VGA_RX_LOCK_EN
    assign pix_en = (state_q == LOCKED);
`else
    assign pix_en = (state_q != SEARCH);
`endif

    assign in_win = (h_cnt_d >= H_ACT_LO) && (h_cnt_d < H_ACT_HI) &&
                    (v_cnt_d >= V_ACT_LO) && (v_cnt_d < V_ACT_HI);

    // Pixel outputs are zero outside valid cycles so the consumer never sees stale data.
    always_comb begin
        pix_valid_d   = in_win && pix_en;
        pix_data_d    = '0;
        pix_x_d       = '0;
        pix_y_d       = '0;
        if (pix_valid_d) begin
            pix_data_d = s_rgb_q;
            pix_x_d    = h_cnt_d - H_ACT_LO;
            pix_y_d    = v_cnt_d - V_ACT_LO;
        end
        frame_start_d = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q       <= SEARCH;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            frame_len_q   <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            locked_q      <= 1'b0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_len_q   <= frame_len_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            locked_q      <= (state_d == LOCKED);
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pixel_data  = pix_data_q;
    assign bus.pixel_valid = pix_valid_q;
    assign bus.pixel_xpos  = pix_x_q;
    assign bus.pixel_ypos  = pix_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.h_total     = h_total_q;
    assign bus.v_total     = v_total_q;
endmodule

// File: doc/vga_rx.md
# vga_rx

Receive-side counterpart of the VGA timing driver: samples an incoming 640x480-style VGA stream (active-low hs/vs plus RGB565) on the pixel clock and locks to its line and frame timing. It reconstructs pixel coordinates and delivers active-window pixels with a valid strobe. It sits between a video source (loopback or external port) and the frame-buffer write path, and reports measured line/frame totals for status.

## Interface
Parameters (window position, in pixel clocks / lines):
- H_SYNC, 96, hs low width expected; active start offset component
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- V_SYNC, 2, vs width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines per frame

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- sys_rst  in  1  reset, synchronous, active-high
- vga_hs  in  1  line sync, active low
- vga_vs  in  1  frame sync, active low
- vga_rgb  in  16  RGB565 pixel
- pixel_data  out  16  captured pixel, 0 when pixel_valid low
- pixel_valid  out  1  pixel_data/xpos/ypos valid
- pixel_xpos  out  11  column 0..H_DISP-1, 0 when invalid
- pixel_ypos  out  11  row 0..V_DISP-1, 0 when invalid
- frame_start  out  1  one-cycle pulse with pixel (0,0)
- locked  out  1  timing stable
- h_total  out  11  measured clocks per line
- v_total  out  11  measured lines per frame

## Operation
- Input stage: vga_hs/vs/rgb registered once (s_hs, s_vs, s_rgb); one further register (s_hs_d, s_vs_d) for edge detect. Nothing uses the raw pins otherwise.
- hs fall: s_hs=0 and s_hs_d=1. vs fall: s_vs=0 and s_vs_d=1.
- h_pos (11 bit): 0 on the s_* sample where hs fall is detected, +1 each cycle after; saturates at 2047.
- v_pos (11 bit): on hs fall, 0 if vs fall in the same cycle, else +1; saturates at 2047. vs fall without hs fall in the same cycle also sets v_pos to 0.
- At hs fall: line_len = h_pos_prev+1 (clocks since previous hs fall). At vs fall: frame_len = v_pos_prev+1.
- FSM states: SEARCH, MEASURE, CHECK, LOCKED.
  - SEARCH: wait for vs fall -> MEASURE.
  - MEASURE: at next vs fall, latch h_total=line_len (last line), v_total=frame_len -> CHECK.
  - CHECK: at next vs fall, if line_len==h_total and frame_len==v_total -> LOCKED, else re-latch both and stay in CHECK.
  - LOCKED: at every hs fall, line_len!=h_total -> SEARCH; at every vs fall, frame_len!=v_total -> SEARCH; any counter saturation -> SEARCH.
- locked = (state==LOCKED). Leaving LOCKED clears locked the next cycle; h_total/v_total hold last values.
- Active window: h_pos in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_pos in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP). pixel_xpos = h_pos-(H_SYNC+H_BACK), pixel_ypos = v_pos-(V_SYNC+V_BACK), 11-bit unsigned.
- frame_start high on the valid pixel with xpos=0, ypos=0 only.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0, sync pipeline regs reset to 1 (idle-high, no false edge after reset).
- Pin-to-output latency: 2 vga_clk cycles from vga_rgb at pin to pixel_data, all pixel outputs registered together.
- h_pos is aligned with the s_* stream: with a driver counting from 0 at hs assertion, h_pos equals the driver's horizontal count for the same pixel.
- Simultaneous hs fall and vs fall (normal driver case): both processed same cycle; vs handling uses frame_len including the ending line.
- locked rises 1 cycle after the third vs fall detected after reset (first = SEARCH exit).
- Reset mid-frame: immediate return to SEARCH, pixel_valid low next cycle; no partial output.

## Configuration
- VGA_RX_LOCK_EN defined: pixel_valid/frame_start asserted only while locked.
- Not defined: asserted in window whenever state != SEARCH; locked, h_total, v_total still computed as above.

## Test plan
- Driver-model source, H 8/4/16/4 (total 32), V 2/2/8/2 (total 14), params matched -> locked after 3rd vs fall; h_total=32, v_total=14; 128 valid pixels per frame, xpos 0..15, ypos 0..7.
- Ramp RGB = driver pixel index -> pixel_data equals value driven 2 cycles earlier; frame_start exactly once per frame at (0,0).
- Locked, stretch one line to 33 clocks -> locked low next cycle after that hs fall; relock after 3 further vs falls.
- Change v_total 14->15 during CHECK -> stays unlocked one extra frame, then locks with v_total=15.
- sys_rst pulsed mid-active-line -> all outputs 0 next cycle; relock behaviour as first case.
- VGA_RX_LOCK_EN undefined -> pixels valid in frame 2 (state MEASURE) before locked rises.
